exp_vector_sequencer: RTL and testbench

Sequencer that sits directly upstream of the `exponent` unit and feeds it one element at a time. It accepts a vector of up to DEPTH float32 values on a valid/ready input stream and buffers it. It then drives the unit's X/enb/ack handshake once per element, stores each result Y in place, and streams the results out in order with a last marker. It is the front end of the softmax/activation path: it turns the single-shot `exponent` interface into a vector stream.

---
 rtl/exp_vector_sequencer.sv | 140 ++++++++++++++
 tb/tb_exp_vector_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/exp_vector_sequencer.sv
// Vector front end for the single-shot exponent unit: buffers a vector, runs the unit once per
// element with an ack timeout, writes each result back in place, then streams the results out.
module exp_vector_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] exp_x,
  output logic                  exp_enb,
  input  logic [DATA_WIDTH-1:0] exp_y,
  input  logic                  exp_ack,
  output logic                  busy,
  output logic                  err
);

  // state | meaning
  // LOAD  | idle, accepting input beats into the buffer
  // ISSUE | present buf[idx] with exp_enb low to clear the unit
  // WAIT  | exp_enb high, waiting for ack or timeout
  // DRAIN | stream buffered results downstream
  typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_WAIT, S_DRAIN} state_t;

  localparam int CW = ADDR_WIDTH + 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]         LAST_SLOT = CW'(DEPTH - 1);
  localparam logic [WW-1:0]         WAIT_LOAD = WW'(TIMEOUT - 1);
  localparam logic [DATA_WIDTH-1:0] QNAN      = DATA_WIDTH'(32'h7FC0_0000);

  state_t                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [WW-1:0]         wait_q, wait_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] buf_q [DEPTH];
  logic [DATA_WIDTH-1:0] buf_d [DEPTH];

  logic is_last_idx;
  logic elem_done;

  assign is_last_idx = ({1'b0, idx_q} == (count_q - CW'(1)));

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    wait_d    = wait_q;
    err_d     = err_q;
    buf_d     = buf_q;
    elem_done = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          buf_d[count_q[ADDR_WIDTH-1:0]] = in_data;
          count_d = count_q + CW'(1);
          // a beat that fills the last slot closes the vector regardless of in_last
          if (in_last || (count_q == LAST_SLOT)) begin
            idx_d   = '0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        wait_d  = WAIT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (exp_ack) begin
          buf_d[idx_q] = exp_y;
          elem_done    = 1'b1;
        end else if (wait_q == '0) begin
          buf_d[idx_q] = QNAN;
          err_d        = 1'b1;
          elem_done    = 1'b1;
        end else begin
          wait_d = wait_q - WW'(1);
        end
        if (elem_done) begin
          if (is_last_idx) begin
            idx_d   = '0;
            state_d = S_DRAIN;
          end else begin
            idx_d   = idx_q + ADDR_WIDTH'(1);
            state_d = S_ISSUE;
          end
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (is_last_idx) begin
            count_d = '0;
            idx_d   = '0;
            state_d = S_LOAD;
          end else begin
            idx_d = idx_q + ADDR_WIDTH'(1);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // buffer contents are don't-care after reset, so only control state is reset
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
    if (rst) begin
      state_q <= S_LOAD;
      count_q <= '0;
      idx_q   <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_DRAIN);
  assign out_last  = (state_q == S_DRAIN) && is_last_idx;
  assign out_data  = (state_q == S_DRAIN) ? buf_q[idx_q] : '0;
  assign exp_enb   = (state_q == S_WAIT);
  assign exp_x     = ((state_q == S_ISSUE) || (state_q == S_WAIT)) ? buf_q[idx_q] : '0;
  assign busy      = !((state_q == S_LOAD) && (count_q == '0));
  assign err       = err_q;

endmodule

// File: tb/tb_exp_vector_sequencer.sv
// Directed bench for exp_vector_sequencer with a 7-cycle Y=X+1 exponent model.
module tb_exp_vector_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic [31:0] exp_x, exp_y;
  logic        exp_enb, exp_ack;
  logic        busy, err;

  exp_vector_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .exp_x(exp_x), .exp_enb(exp_enb), .exp_y(exp_y), .exp_ack(exp_ack),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // exponent model: ack on the 7th enabled cycle; optional never-ack and held-ack operands
  logic [6:0]  m_cnt = '0;
  logic [1:0]  hold_left = '0;
  logic [31:0] noack_x = 32'hFFFF_FFFF;
  logic [31:0] hold_x  = 32'hFFFF_FFFF;

  always @(posedge clk) begin
    m_cnt <= exp_enb ? m_cnt + 7'd1 : 7'd0;
    if (exp_enb && m_cnt == 7'd6 && exp_x == hold_x) hold_left <= 2'd2;
    else if (hold_left != 2'd0) hold_left <= hold_left - 2'd1;
  end

  assign exp_ack = (exp_enb && m_cnt == 7'd6 && exp_x != noack_x) || (hold_left != 2'd0);
  assign exp_y   = (hold_left != 2'd0) ? exp_x + 32'd2 : exp_x + 32'd1;

  typedef struct {
    logic [31:0] x;
    logic        il;
    logic [31:0] y;
    logic        ol;
  } vec_t;

  vec_t tbl [16];
  bit   bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic run_vec(input int lo, input int n, input bit bp, input bit chk_pat);
    logic [7:0]  pat;
    logic        xok, prev_stall;
    logic [31:0] prev_d;
    logic        prev_l;
    int          got, k;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = tbl[lo + i].x;
      in_last  = tbl[lo + i].il;
      @(posedge clk); #1;
      if (i == 0 && n > 1) chk("busy_loading", busy, 1'b1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    chk("in_ready_after_last_beat", in_ready, 1'b0);
    if (chk_pat) begin
      for (int e = 0; e < n; e++) begin
        pat = '0;
        xok = 1'b1;
        for (int c = 0; c < 8; c++) begin
          if (!(e == 0 && c == 0)) @(negedge clk);
          pat = {pat[6:0], exp_enb};
          if (c > 0 && exp_x !== tbl[lo + e].x) xok = 1'b0;
        end
        chk("enb_pattern", {24'd0, pat}, 32'h7F);
        chk("exp_x_stable", xok, 1'b1);
      end
    end
    got = 0;
    k = 0;
    prev_stall = 1'b0;
    prev_d = '0;
    prev_l = 1'b0;
    for (int cyc = 0; cyc < 2000 && got < n; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        out_ready = bp ? bp_pat[k % 4] : 1'b1;
        k++;
        if (prev_stall) begin
          chk("stall_data", out_data, prev_d);
          chk("stall_last", out_last, prev_l);
        end
        prev_stall = !out_ready;
        prev_d = out_data;
        prev_l = out_last;
        if (out_ready) begin
          chk("out_data", out_data, tbl[lo + got].y);
          chk("out_last", out_last, tbl[lo + got].ol);
          got++;
        end
      end else begin
        out_ready = 1'b0;
      end
    end
    if (got != n) chk("drain_beats", got, n);
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_drain", in_ready, 1'b1);
    chk("out_valid_after_drain", out_valid, 1'b0);
  endtask

  initial begin
    tbl[0]  = '{32'h3F566CF4, 1'b0, 32'h3F566CF5, 1'b0};
    tbl[1]  = '{32'hBF75C28F, 1'b0, 32'hBF75C290, 1'b0};
    tbl[2]  = '{32'h3F800000, 1'b1, 32'h3F800001, 1'b1};
    tbl[3]  = '{32'h40000000, 1'b0, 32'h40000001, 1'b0};
    tbl[4]  = '{32'h40400000, 1'b0, 32'h40400001, 1'b0};
    tbl[5]  = '{32'h40800000, 1'b0, 32'h40800001, 1'b0};
    tbl[6]  = '{32'h40A00000, 1'b0, 32'h40A00001, 1'b0};
    tbl[7]  = '{32'h40C00000, 1'b0, 32'h40C00001, 1'b0};
    tbl[8]  = '{32'h40E00000, 1'b0, 32'h40E00001, 1'b0};
    tbl[9]  = '{32'h41000000, 1'b0, 32'h41000001, 1'b0};
    tbl[10] = '{32'h41100000, 1'b0, 32'h41100001, 1'b1};
    tbl[11] = '{32'h3F000000, 1'b0, 32'h7FC00000, 1'b0};
    tbl[12] = '{32'h3E800000, 1'b1, 32'h3E800001, 1'b1};
    tbl[13] = '{32'h12345678, 1'b0, 32'h12345679, 1'b0};
    tbl[14] = '{32'h0BADF00D, 1'b1, 32'h0BADF00E, 1'b1};
    tbl[15] = '{32'h00000005, 1'b1, 32'h00000006, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_exp_enb", exp_enb, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_exp_x", exp_x, 32'h0);
    chk("rst_out_data", out_data, 32'h0);

    run_vec(0, 3, 1'b0, 1'b1);
    chk("err_after_basic", err, 1'b0);
    run_vec(3, 8, 1'b0, 1'b1);
    run_vec(0, 3, 1'b1, 1'b1);

    noack_x = tbl[11].x;
    run_vec(11, 2, 1'b0, 1'b0);
    chk("err_after_timeout", err, 1'b1);
    noack_x = 32'hFFFF_FFFF;

    hold_x = tbl[14].x;
    run_vec(13, 2, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    hold_x = 32'hFFFF_FFFF;
    chk("err_sticky", err, 1'b1);

    // reset during the WAIT of element 2
    in_valid = 1'b1;
    in_data = 32'h00000100;
    in_last = 1'b0;
    @(posedge clk); #1;
    in_data = 32'h00000200;
    in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (11) @(negedge clk);
    chk("pre_rst_enb", exp_enb, 1'b1);
    chk("pre_rst_exp_x", exp_x, 32'h00000200);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_enb", exp_enb, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_err", err, 1'b0);
    run_vec(15, 1, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
